// File: rtl/siren_pkg.sv
// ============================================================================
// Module   : siren_pkg
// Purpose  : Shared mode encodings for the multi-tone siren.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package siren_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_WAIL = 2'b01,
        MODE_YELP = 2'b10,
        MODE_HILO = 2'b11
    } mode_e;

endpackage

`default_nettype wire

// File: rtl/tone_divider.sv
// ============================================================================
// Module   : tone_divider
// Purpose  : Reload/toggle counter producing a square wave of half-period div+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_divider #(
    parameter int DIV_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             speaker
);

    logic [DIV_W-1:0] counter_q, counter_d;
    logic             speaker_q, speaker_d;

    // div is only looked at on the reload cycle, so mid-count changes wait a period
    always_comb begin
        counter_d = counter_q;
        speaker_d = speaker_q;
        if (clr) begin
            counter_d = '0;
            speaker_d = 1'b0;
        end else if (en) begin
            if (counter_q == '0) begin
                counter_d = div;
                speaker_d = ~speaker_q;
            end else begin
                counter_d = counter_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_q <= '0;
            speaker_q <= 1'b0;
        end else begin
            counter_q <= counter_d;
            speaker_q <= speaker_d;
        end
    end

    assign speaker = speaker_q;

endmodule

`default_nettype wire

// File: rtl/multi_siren.sv
// ============================================================================
// Module   : multi_siren
// Purpose  : Wail / yelp / hi-lo siren tone generator with a swept divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_siren
    import siren_pkg::*;
#(
    parameter int                        SWEEP_W    = 23,
    parameter int                        RAMP_W     = 7,
    parameter int                        SHIFT      = 6,
    parameter int                        YELP_SHIFT = 4,
    parameter logic [2+RAMP_W+SHIFT-1:0] HI_DIV     = 15'h2000,
    parameter logic [2+RAMP_W+SHIFT-1:0] LO_DIV     = 15'h3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    output logic       speaker,
    output logic       active
);

    localparam int DIV_W = 2 + RAMP_W + SHIFT;

    mode_e              mode_q, mode_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic               active_q, active_d;

    logic               w_change;
    logic               w_run;
    logic               w_clr;
    logic [RAMP_W-1:0]  w_ramp;
    logic [DIV_W-1:0]   w_divider;

    always_comb begin
        mode_d    = mode_e'(mode);
        active_d  = (mode_d != MODE_OFF);
        w_change  = (mode_d != mode_q);
        w_run     = (mode_q != MODE_OFF);
        w_clr     = w_change || !w_run;
        sweep_d   = w_clr ? '0 : sweep_q + SWEEP_W'(1);

        w_ramp    = '0;
        w_divider = '0;
        case (mode_q)
            MODE_WAIL: begin
                // MSB of the sweep picks rising or falling half of the triangle
                w_ramp    = sweep_q[SWEEP_W-1] ? sweep_q[SWEEP_W-2 -: RAMP_W]
                                               : ~sweep_q[SWEEP_W-2 -: RAMP_W];
                w_divider = {2'b01, w_ramp, {SHIFT{1'b0}}};
            end
            MODE_YELP: begin
                w_ramp    = ~sweep_q[SWEEP_W-1-YELP_SHIFT -: RAMP_W];
                w_divider = {2'b01, w_ramp, {SHIFT{1'b0}}};
            end
            MODE_HILO: begin
                w_divider = sweep_q[SWEEP_W-1] ? HI_DIV : LO_DIV;
            end
            default: begin
                w_ramp    = '0;
                w_divider = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            sweep_q  <= '0;
            active_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            sweep_q  <= sweep_d;
            active_q <= active_d;
        end
    end

    tone_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .en      (w_run),
        .div     (w_divider),
        .speaker (speaker)
    );

    assign active = active_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_siren.sv
// ============================================================================
// Module   : tb_multi_siren
// Purpose  : Directed self-checking bench for multi_siren (8-bit sweep build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_siren;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       speaker;
    logic       active;

    int n_cmp = 0;
    int n_bad = 0;

    // Half-periods (divider+1) for wail from entry, hand-derived; crosses two wraps
    int wail_hp [24] = '{31, 29, 25, 21, 19, 17, 17, 19, 23, 25, 29, 31,
                         29, 25, 21, 19, 17, 17, 19, 23, 25, 29, 31, 29};
    int yelp_hp [8]  = '{31, 25, 17, 29, 23, 17, 29, 21};

    multi_siren #(
        .SWEEP_W    (8),
        .RAMP_W     (3),
        .SHIFT      (1),
        .YELP_SHIFT (2),
        .HI_DIV     (6'd10),
        .LO_DIV     (6'd20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .speaker (speaker),
        .active  (active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until speaker changes; -1 if it never does within the budget
    task automatic wait_toggle(output int n);
        logic prev;
        bit   done;
        prev = speaker;
        done = 1'b0;
        n    = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            n++;
            if (speaker !== prev) begin
                done = 1'b1;
            end else if (n >= 200) begin
                n    = -1;
                done = 1'b1;
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_speaker"}, int'(speaker), 0);
        check_eq({tag, "_active"},  int'(active), 1);
        check_eq({tag, "_sweep"},   int'(dut.sweep_q), 0);
        check_eq({tag, "_counter"}, int'(dut.u_div.counter_q), 0);
    endtask

    initial begin
        int n;
        int viol;

        rst  = 1'b1;
        mode = 2'b00;
        #1;
        check_eq("rst_speaker", int'(speaker), 0);
        check_eq("rst_active",  int'(active), 0);
        tick(3);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Wail from a fresh entry through two sweep wraps
        mode = 2'b01;
        wait_toggle(n);
        check_eq("wail_first", n, 2);
        for (int i = 0; i < 24; i++) begin
            wait_toggle(n);
            check_eq($sformatf("wail_hp%0d", i), n, wail_hp[i]);
        end

        // Mid-count switch to hi-lo with speaker high
        tick(5);
        mode = 2'b11;
        tick(1);
        check_cleared("hilo_entry");
        wait_toggle(n);
        check_eq("hilo_first", n, 1);
        for (int i = 0; i < 7; i++) begin
            wait_toggle(n);
            check_eq($sformatf("hilo_lo%0d", i), n, 21);
        end
        for (int i = 0; i < 3; i++) begin
            wait_toggle(n);
            check_eq($sformatf("hilo_hi%0d", i), n, 11);
        end

        // Switch to yelp right after a reload (counter loaded, speaker high)
        mode = 2'b10;
        tick(1);
        check_cleared("yelp_entry");
        wait_toggle(n);
        check_eq("yelp_first", n, 1);
        for (int i = 0; i < 8; i++) begin
            wait_toggle(n);
            check_eq($sformatf("yelp_hp%0d", i), n, yelp_hp[i]);
        end

        // Asynchronous reset between edges while the speaker is high
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_speaker", int'(speaker), 0);
        check_eq("arst_active",  int'(active), 0);
        check_eq("arst_sweep",   int'(dut.sweep_q), 0);
        mode = 2'b01;
        @(negedge clk);
        rst = 1'b0;
        wait_toggle(n);
        check_eq("arst_first", n, 2);
        wait_toggle(n);
        check_eq("arst_hp0", n, 31);

        // Off: everything held quiet
        mode = 2'b00;
        viol = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (speaker !== 1'b0 || active !== 1'b0) viol++;
        end
        check_eq("off_hold_viol", viol, 0);
        check_eq("off_sweep",     int'(dut.sweep_q), 0);
        check_eq("off_counter",   int'(dut.u_div.counter_q), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
